div_unit: RTL and testbench
===========================

# div_unit

Multi-cycle radix-2 restoring divider for DIV/DIVU, instantiated inside the execute stage and driven by the operands registered out of the ID/EX pipeline register. The execute stage raises `start_i` and holds the pipeline stalled until `ready_o` is high. It then writes the 64-bit result to HI/LO: remainder goes to HI, quotient goes to LO.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  clock; all state changes on the rising edge
- `rst`  in  1  reset, synchronous, active-high
- `signed_div_i`  in  1  1 = DIV (signed), 0 = DIVU
- `opdata1_i`  in  32  dividend
- `opdata2_i`  in  32  divisor
- `start_i`  in  1  request; held high by EX until it consumes the result
- `annul_i`  in  1  cancel (exception/flush); aborts an in-flight division
- `result_o`  out  64  {remainder[31:0], quotient[31:0]}; registered
- `ready_o`  out  1  result valid; registered

## Operation
States:
- FREE
- BYZERO
- ON
- END

Transitions:
- FREE:
  - `start_i`=1, `annul_i`=0, divisor = 0 → BYZERO
  - `start_i`=1, `annul_i`=0, divisor ≠ 0 → ON
    - latch operand magnitudes
    - clear the 6-bit iteration counter `cnt`
    - load the 65-bit working register with {32'b0, |dividend|, 1'b0}
  - otherwise stay in FREE
- BYZERO:
  - register result = 64'h0
  - go to END unconditionally
- ON:
  - `annul_i`=1 → FREE on the next edge; nothing is written
  - `cnt` < 32: one iteration per cycle, then `cnt`++
    - trial = upper 33 bits − {1'b0, |divisor|}
    - trial negative: shift the working register left, shifting in 0
    - trial non-negative: working register = {trial[31:0], low half, 1'b1} (shift in 1)
  - `cnt` == 32: apply sign correction, register `result_o`, go to END
- END:
  - `ready_o`=1; `result_o` is held stable
  - `start_i`=0 → FREE; `ready_o` and `result_o` clear to 0 on that edge

Signed rules, when `signed_div_i`=1:
- Negative operands are two's-complement negated before division.
- Quotient is negated when the operand signs differ.
- Remainder takes the sign of the dividend.
- 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000, remainder 0. This is wrap-around behaviour, with no trap.

Other rules:
- Operand changes while in ON, BYZERO or END are ignored; operands are latched once at start.
- `annul_i` in BYZERO or END has no effect. EX is responsible for dropping `start_i`.

## Timing
Reset values:
- state = FREE
- `ready_o` = 0
- `result_o` = 64'h0
- `cnt` = 0

Latency:
- Non-zero divisor: `ready_o` rises 34 edges after the edge that sampled `start_i`. That is 1 accept + 32 iterations + 1 finalize; the 34th edge is the END entry edge.
- Zero divisor: `ready_o` rises 2 edges after the accept edge.

Handshake:
- `ready_o` stays high for every cycle that `start_i` stays high in END.
- `ready_o` falls on the edge after `start_i` drops.
- A new `start_i` is accepted no earlier than the cycle after returning to FREE.

Boundary conditions:
- Reset mid-operation: `rst` in any state forces the reset values on that edge.
- `rst` has priority over `annul_i`; `annul_i` has priority over iteration.

## Configuration
- `DIV_SIGNED_EN` defined: signed path active as described above.
- `DIV_SIGNED_EN` undefined:
  - `signed_div_i` is ignored; all operations are unsigned.
  - The negation and sign-correction logic is not synthesized.
  - The decoder is then required to trap DIV as a reserved instruction.

## Test plan
- Unsigned: `signed_div_i`=0, 100 / 7, `start_i` held → `ready_o` high 34 edges after accept; `result_o` = {32'd2, 32'd14}.
- Signed: `signed_div_i`=1, −7 / 2 → `result_o` = {32'hFFFFFFFF, 32'hFFFFFFFD} (rem −1, quot −3). Also run 7 / −2 → {32'd1, 32'hFFFFFFFD}.
- Zero divisor: 5 / 0 → `ready_o` high 2 edges after accept; `result_o` = 64'h0. Then drop `start_i` → `ready_o` = 0 on the next edge.
- Annul: start 0xFFFFFFFF / 3, assert `annul_i` for one cycle at iteration 10 → FREE next edge, `ready_o` never rises. A fresh start of 9 / 3 then yields {0, 3}.
- Reset mid-division at iteration 20 → next edge `ready_o`=0, `result_o`=0, state FREE.
- Hold: keep `start_i` high 5 extra cycles in END while toggling the operand inputs → `result_o` and `ready_o` stay constant.

Source files
------------

// File: rtl/div_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_unit_if : request/result bundle between the EX stage and divider |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
interface div_unit_if;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_unit : multi-cycle radix-2 restoring divider, {rem, quot} result |
// | Signed DIV support is built only when DIV_SIGNED_EN is defined.      |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module div_unit (
  input  logic        clk,
  input  logic        rst,
  div_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_BYZERO = 2'd1,
    ST_ON     = 2'd2,
    ST_END    = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [64:0] work_q, work_d;
  logic [31:0] divisor_q, divisor_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic [32:0] trial;
  logic [31:0] mag1;
  logic [31:0] mag2;
  logic [31:0] quot;
  logic [31:0] rem;

  // Partial remainder is always below the divisor, so the 33-bit difference
  // never overflows and bit 32 is a true sign bit.
  assign trial = work_q[64:32] - {1'b0, divisor_q};

`ifdef DIV_SIGNED_EN
  logic neg_quot_q, neg_quot_d;
  logic neg_rem_q, neg_rem_d;

  assign mag1 = (bus.signed_div_i && bus.opdata1_i[31]) ? (32'd0 - bus.opdata1_i) : bus.opdata1_i;
  assign mag2 = (bus.signed_div_i && bus.opdata2_i[31]) ? (32'd0 - bus.opdata2_i) : bus.opdata2_i;
  assign quot = neg_quot_q ? (32'd0 - work_q[31:0])  : work_q[31:0];
  assign rem  = neg_rem_q  ? (32'd0 - work_q[64:33]) : work_q[64:33];

  always_ff @(posedge clk) begin
    if (rst) begin
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else begin
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
    end
  end

  always_comb begin
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    if (state_q == ST_FREE && bus.start_i && !bus.annul_i) begin
      neg_quot_d = bus.signed_div_i && (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
      neg_rem_d  = bus.signed_div_i && bus.opdata1_i[31];
    end
  end
`else
  logic unused_signed_div;

  assign unused_signed_div = bus.signed_div_i;
  assign mag1 = bus.opdata1_i;
  assign mag2 = bus.opdata2_i;
  assign quot = work_q[31:0];
  assign rem  = work_q[64:33];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FREE;
      cnt_q     <= 6'd0;
      work_q    <= 65'd0;
      divisor_q <= 32'd0;
      result_q  <= 64'd0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    result_d  = result_q;
    ready_d   = ready_q;

    case (state_q)
      ST_FREE: begin
        if (bus.start_i && !bus.annul_i) begin
          if (bus.opdata2_i == 32'd0) begin
            state_d = ST_BYZERO;
          end else begin
            state_d   = ST_ON;
            cnt_d     = 6'd0;
            divisor_d = mag2;
            work_d    = {32'd0, mag1, 1'b0};
          end
        end
      end

      ST_BYZERO: begin
        result_d = 64'd0;
        ready_d  = 1'b1;
        state_d  = ST_END;
      end

      ST_ON: begin
        if (bus.annul_i) begin
          state_d = ST_FREE;
        end else if (cnt_q < 6'd32) begin
          if (trial[32]) begin
            work_d = {work_q[63:0], 1'b0};
          end else begin
            work_d = {trial[31:0], work_q[31:0], 1'b1};
          end
          cnt_d = cnt_q + 6'd1;
        end else begin
          result_d = {rem, quot};
          ready_d  = 1'b1;
          state_d  = ST_END;
        end
      end

      ST_END: begin
        if (!bus.start_i) begin
          state_d  = ST_FREE;
          ready_d  = 1'b0;
          result_d = 64'd0;
        end
      end

      default: begin
        state_d = ST_FREE;
      end
    endcase
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_div_unit : scoreboard bench for div_unit                          |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module tb_div_unit;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  logic [63:0] sb_q[$];

  div_unit_if bus ();

  div_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    logic        s;
    logic [31:0] ma, mb, q, r;
`ifdef DIV_SIGNED_EN
    s = sgn;
`else
    s = 1'b0 & sgn;
`endif
    if (b == 32'd0) return 64'd0;
    ma = (s && a[31]) ? -a : a;
    mb = (s && b[31]) ? -b : b;
    q  = ma / mb;
    r  = ma % mb;
    if (s && (a[31] ^ b[31])) q = -q;
    if (s && a[31]) r = -r;
    return {r, q};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one division, hold start for `extra` cycles in END, then release.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sgn, input logic [63:0] exp, input int extra);
    int          n;
    int          lat;
    logic [63:0] e;
    lat = (b == 32'd0) ? 2 : 34;
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    sb_q.push_back(exp);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.ready_o && n < 60);
    check({tag, "_lat"}, 64'(n), 64'(lat));
    e = sb_q.pop_front();
    check({tag, "_res"}, bus.result_o, e);
    for (int k = 0; k < extra; k++) begin
      bus.opdata1_i    = $urandom;
      bus.opdata2_i    = $urandom;
      bus.signed_div_i = ~bus.signed_div_i;
      tick();
      check({tag, "_hold_rdy"}, 64'(bus.ready_o), 64'd1);
      check({tag, "_hold_res"}, bus.result_o, e);
    end
    bus.start_i = 1'b0;
    tick();
    check({tag, "_drop_rdy"}, 64'(bus.ready_o), 64'd0);
    check({tag, "_drop_res"}, bus.result_o, 64'd0);
  endtask

  initial begin
    int          seen;
    logic [31:0] ra, rb;
    logic        rs;
    vectors          = 0;
    miscompares      = 0;
    rst              = 1'b1;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd0;
    bus.opdata2_i    = 32'd0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    tick();
    tick();
    check("reset_rdy", 64'(bus.ready_o), 64'd0);
    check("reset_res", bus.result_o, 64'd0);
    rst = 1'b0;
    tick();

    run_div("u100_7", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 0);
`ifdef DIV_SIGNED_EN
    run_div("s_m7_2", 32'hFFFFFFF9, 32'd2, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 0);
    run_div("s_7_m2", 32'd7, 32'hFFFFFFFE, 1'b1, {32'd1, 32'hFFFFFFFD}, 0);
    run_div("s_min_m1", 32'h80000000, 32'hFFFFFFFF, 1'b1, {32'd0, 32'h80000000}, 0);
`else
    run_div("s_m7_2", 32'hFFFFFFF9, 32'd2, 1'b1, {32'd1, 32'h7FFFFFFC}, 0);
    run_div("s_7_m2", 32'd7, 32'hFFFFFFFE, 1'b1, {32'd7, 32'd0}, 0);
    run_div("s_min_m1", 32'h80000000, 32'hFFFFFFFF, 1'b1, {32'h80000000, 32'd0}, 0);
`endif
    run_div("zero_div", 32'd5, 32'd0, 1'b0, 64'd0, 0);
    run_div("u_max_1", 32'hFFFFFFFF, 32'd1, 1'b0, {32'd0, 32'hFFFFFFFF}, 0);
    run_div("u_big_big", 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, {32'd1, 32'd1}, 0);

    // Annul at iteration 10: the division must vanish without ever signalling.
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'hFFFFFFFF;
    bus.opdata2_i    = 32'd3;
    bus.start_i      = 1'b1;
    tick();
    bus.start_i = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    bus.annul_i = 1'b1;
    tick();
    bus.annul_i = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.ready_o) seen++;
      tick();
    end
    check("annul_no_rdy", 64'(seen), 64'd0);
    run_div("after_annul", 32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 0);

    // Reset at iteration 20.
    bus.opdata1_i = 32'd1000;
    bus.opdata2_i = 32'd3;
    bus.start_i   = 1'b1;
    tick();
    bus.start_i = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    rst = 1'b1;
    tick();
    check("rst_mid_rdy", 64'(bus.ready_o), 64'd0);
    check("rst_mid_res", bus.result_o, 64'd0);
    rst = 1'b0;
    tick();
    run_div("after_rst", 32'd1000, 32'd3, 1'b0, {32'd1, 32'd333}, 0);

    run_div("hold", 32'd12345, 32'd67, 1'b0, ref_div(32'd12345, 32'd67, 1'b0), 5);

    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = (i == 3) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
      rs = i[0];
      run_div("rand", ra, rb, rs, ref_div(ra, rb, rs), 0);
    end

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
